// File: rtl/round_pkg.sv
// Shared definitions for the round sequencer: FSM state encoding, timer
// load width and the LFSR seed/tap constants used by lfsr16.
package round_pkg;

  localparam int          TIME_W    = 5;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

  // One right-shifting Galois step for x^16+x^14+x^13+x^11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = v >> 1;
    lfsr_step = v[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/round_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR used to draw round targets.
// It steps every clock so the target depends on how long the player waited.
module lfsr16
  import round_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // Advance one step per cycle; the all-zero lock-up state is never
  // reachable from the seed, but is steered back to the seed if ever seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (q == 16'h0000) begin
      q <= LFSR_SEED;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Game-round sequencer sitting in front of the seconds countdown timer.
// Draws a target, loads the timer, judges submissions and keeps score.
// Optional feature macro: SPEEDUP_EN -- each correct answer shortens the
// next round by one second, never below MIN_TIME.
module round_ctrl
  import round_pkg::*;
#(
  parameter int                NUM_W      = 8,
  parameter int                SCORE_W    = 8,
  parameter logic [TIME_W-1:0] ROUND_TIME = 5'd10,
  parameter logic [TIME_W-1:0] MIN_TIME   = 5'd3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               submit_btn,
  input  logic [NUM_W-1:0]   sw,
  input  logic               end_f,
  output logic               time_f,
  output logic [TIME_W-1:0]  time_v,
  output logic [NUM_W-1:0]   target,
  output logic [SCORE_W-1:0] score,
  output logic               hit,
  output logic               miss,
  output logic               game_over
);

  state_t state;
  state_t next_state;

  logic [15:0] lfsr_q;

  // Seconds that the next LOAD will hand to the timer.
  logic [TIME_W-1:0] cur_time;

  logic               is_correct;
  logic               play_hit;
  logic               play_miss;
  logic               game_start;

  logic               time_f_d;
  logic [TIME_W-1:0]  time_v_d;
  logic [NUM_W-1:0]   target_d;
  logic [SCORE_W-1:0] score_d;
  logic               hit_d;
  logic               miss_d;
  logic               game_over_d;
  logic [TIME_W-1:0]  cur_time_d;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Target width is carved from the low LFSR bits; the rest are spare.
  generate
    if (NUM_W < 16) begin : g_lfsr_spare
      logic lfsr_spare_unused;
      assign lfsr_spare_unused = ^lfsr_q[15:NUM_W];
    end
  endgenerate

  assign is_correct = (sw == target);
  assign play_hit   = (state == PLAY) && !end_f && submit_btn && is_correct;
  assign play_miss  = (state == PLAY) && !end_f && submit_btn && !is_correct;
  assign game_start = ((state == IDLE) || (state == OVER)) && start_btn;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; timer expiry outranks any submit made in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_btn) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = PLAY;
      end
      PLAY: begin
        if (end_f) begin
          next_state = OVER;
        end else if (submit_btn && is_correct) begin
          next_state = LOAD;
        end
      end
      OVER: begin
        if (start_btn) begin
          next_state = LOAD;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Next values of every registered output plus the round-time register.
  always_comb begin
    time_f_d    = (next_state == LOAD);
    time_v_d    = time_v;
    target_d    = target;
    score_d     = score;
    hit_d       = play_hit;
    miss_d      = play_miss;
    game_over_d = (next_state == OVER);
    cur_time_d  = cur_time;

    if (game_start) begin
      score_d    = '0;
      cur_time_d = ROUND_TIME;
    end else if (play_hit) begin
      if (score != {SCORE_W{1'b1}}) begin
        score_d = score + 1'b1;
      end
`ifdef SPEEDUP_EN
      if (cur_time > MIN_TIME) begin
        cur_time_d = cur_time - 1'b1;
      end else begin
        cur_time_d = MIN_TIME;
      end
`endif
    end

`ifndef SPEEDUP_EN
    cur_time_d = ROUND_TIME;
`endif

    if (state == LOAD) begin
      target_d = lfsr_q[NUM_W-1:0];
    end

    if (next_state == LOAD) begin
      time_v_d = cur_time_d;
    end
  end

`ifndef SPEEDUP_EN
  // The floor only matters when rounds speed up.
  logic [TIME_W-1:0] min_time_unused;
  assign min_time_unused = MIN_TIME;
`endif

  // Output and round-time registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_f    <= 1'b0;
      time_v    <= ROUND_TIME;
      target    <= '0;
      score     <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
      cur_time  <= ROUND_TIME;
    end else begin
      time_f    <= time_f_d;
      time_v    <= time_v_d;
      target    <= target_d;
      score     <= score_d;
      hit       <= hit_d;
      miss      <= miss_d;
      game_over <= game_over_d;
      cur_time  <= cur_time_d;
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: reset values, start, hit/miss, end_f
// priority, score saturation, mid-game reset and stale end_f handling.
module tb_round_ctrl;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic       submit_btn;
  logic [7:0] sw;
  logic       end_f;
  logic       time_f;
  logic [4:0] time_v;
  logic [7:0] target;
  logic [7:0] score;
  logic       hit;
  logic       miss;
  logic       game_over;

  int vector_count;
  int miscompare_count;

  logic [15:0] model_lfsr;
  logic [7:0]  exp_target;

  round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .submit_btn (submit_btn),
    .sw         (sw),
    .end_f      (end_f),
    .time_f     (time_f),
    .time_v     (time_v),
    .target     (target),
    .score      (score),
    .hit        (hit),
    .miss       (miss),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: Galois, x^16+x^14+x^13+x^11, seeded 16'hACE1.
  always @(posedge clk) begin
    if (rst) begin
      model_lfsr <= 16'hACE1;
    end else if (model_lfsr[0]) begin
      model_lfsr <= (model_lfsr >> 1) ^ 16'hB400;
    end else begin
      model_lfsr <= model_lfsr >> 1;
    end
  end

  function automatic logic [4:0] expTime(input int hits);
`ifdef SPEEDUP_EN
    if (10 - hits < 3) return 5'd3;
    return 5'(10 - hits);
`else
    if (hits < 0) return 5'd0;
    return 5'd10;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one cycle of inputs; pulses drop again after the edge, end_f is a level.
  task automatic applyStimulus(input logic st, input logic sub,
                               input logic [7:0] s, input logic ef);
    start_btn  = st;
    submit_btn = sub;
    sw         = s;
    end_f      = ef;
    tick();
    start_btn  = 1'b0;
    submit_btn = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    rst        = 1'b1;
    start_btn  = 1'b0;
    submit_btn = 1'b0;
    sw         = 8'h00;
    end_f      = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_time_f", 32'(time_f), 32'd0);
    checkOutput("rst_time_v", 32'(time_v), 32'd10);
    checkOutput("rst_target", 32'(target), 32'd0);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_hit", 32'(hit), 32'd0);
    checkOutput("rst_miss", 32'(miss), 32'd0);
    checkOutput("rst_game_over", 32'(game_over), 32'd0);

    // Submit and end_f in IDLE are ignored.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("idle_submit_hit", 32'(hit), 32'd0);
    checkOutput("idle_submit_miss", 32'(miss), 32'd0);
    checkOutput("idle_end_f_over", 32'(game_over), 32'd0);
    end_f = 1'b0;

    // Start: timer loaded the very next cycle.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("start_time_f", 32'(time_f), 32'd1);
    checkOutput("start_time_v", 32'(time_v), 32'd10);
    checkOutput("start_score", 32'(score), 32'd0);
    exp_target = model_lfsr[7:0];
    tick();
    checkOutput("play_time_f", 32'(time_f), 32'd0);
    checkOutput("play_target", 32'(target), 32'(exp_target));

    // Wrong answer: miss, timer untouched, score unchanged.
    applyStimulus(1'b0, 1'b1, exp_target ^ 8'h01, 1'b0);
    checkOutput("wrong_miss", 32'(miss), 32'd1);
    checkOutput("wrong_hit", 32'(hit), 32'd0);
    checkOutput("wrong_time_f", 32'(time_f), 32'd0);
    checkOutput("wrong_score", 32'(score), 32'd0);
    tick();
    checkOutput("wrong_miss_pulse", 32'(miss), 32'd0);

    // Start while playing is ignored.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("play_start_time_f", 32'(time_f), 32'd0);

    // Correct answer: hit and reload together, new target after LOAD.
    applyStimulus(1'b0, 1'b1, exp_target, 1'b0);
    checkOutput("right_hit", 32'(hit), 32'd1);
    checkOutput("right_time_f", 32'(time_f), 32'd1);
    checkOutput("right_time_v", 32'(time_v), 32'(expTime(1)));
    checkOutput("right_score", 32'(score), 32'd1);
    exp_target = model_lfsr[7:0];
    tick();
    checkOutput("right_hit_pulse", 32'(hit), 32'd0);
    checkOutput("right_new_target", 32'(target), 32'(exp_target));

    // Expiry beats a correct submit in the same cycle.
    applyStimulus(1'b0, 1'b1, exp_target, 1'b1);
    checkOutput("end_game_over", 32'(game_over), 32'd1);
    checkOutput("end_no_hit", 32'(hit), 32'd0);
    checkOutput("end_score", 32'(score), 32'd1);
    checkOutput("end_time_f", 32'(time_f), 32'd0);
    applyStimulus(1'b0, 1'b1, exp_target, 1'b0);
    checkOutput("over_held", 32'(game_over), 32'd1);
    checkOutput("over_target", 32'(target), 32'(exp_target));
    checkOutput("over_submit_hit", 32'(hit), 32'd0);

    // Restart: score cleared, full round time restored.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("restart_time_f", 32'(time_f), 32'd1);
    checkOutput("restart_time_v", 32'(time_v), 32'd10);
    checkOutput("restart_score", 32'(score), 32'd0);
    checkOutput("restart_game_over", 32'(game_over), 32'd0);
    exp_target = model_lfsr[7:0];
    tick();

    // 256 correct answers: time sequence at the start, saturation at the end.
    for (int k = 1; k <= 256; k++) begin
      if (k <= 3) checkOutput($sformatf("loop_target_%0d", k), 32'(target), 32'(exp_target));
      applyStimulus(1'b0, 1'b1, target, 1'b0);
      if (k <= 12) checkOutput($sformatf("loop_time_v_%0d", k), 32'(time_v), 32'(expTime(k)));
      if (k <= 3) checkOutput($sformatf("loop_hit_%0d", k), 32'(hit), 32'd1);
      if (k == 255) checkOutput("score_255", 32'(score), 32'hFF);
      if (k == 256) checkOutput("score_sat", 32'(score), 32'hFF);
      exp_target = model_lfsr[7:0];
      tick();
    end

    // Reset mid-game drops straight back to IDLE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_score", 32'(score), 32'd0);
    checkOutput("midrst_target", 32'(target), 32'd0);
    checkOutput("midrst_time_v", 32'(time_v), 32'd10);

    // Stale end_f is ignored through IDLE and LOAD, honoured in PLAY.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("stale_time_f", 32'(time_f), 32'd1);
    checkOutput("stale_time_v", 32'(time_v), 32'd10);
    checkOutput("stale_load_over", 32'(game_over), 32'd0);
    tick();
    checkOutput("stale_play_over", 32'(game_over), 32'd0);
    tick();
    checkOutput("stale_expire_over", 32'(game_over), 32'd1);
    checkOutput("stale_expire_score", 32'(score), 32'd0);
    end_f = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
